// File: rtl/seq_calc_alu.sv
// Multi-cycle unsigned add/sub/mul/div engine with a start/busy/done handshake.
// Mul is radix-2 shift-add and div is restoring; both take WIDTH cycles.
module seq_calc_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] rem,
  output logic             isValid
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  logic [1:0]       op_q;
  logic [CW-1:0]    cnt;
  logic             dz;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2*WIDTH-1:0] mcand, prod;
  logic [WIDTH-1:0] mplier, r_acc, q_acc;

  logic             accept;
  logic [WIDTH:0]   sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic [WIDTH:0]   shifted;
  logic [WIDTH-1:0] diff, r_nxt, q_nxt;
  logic             ge;

  assign accept   = start && (state != RUN);
  assign busy     = (state == RUN);
  assign done     = (state == DONE);
  assign sum      = {1'b0, a_q} + {1'b0, b_q};
  assign prod_nxt = prod + (mplier[0] ? mcand : '0);

  // Partial remainder is always < divisor, so the low WIDTH bits of the
  // difference are exact whenever the trial subtraction succeeds.
  assign shifted  = {r_acc, q_acc[WIDTH-1]};
  assign ge       = (shifted >= {1'b0, b_q});
  assign diff     = shifted[WIDTH-1:0] - b_q;
  assign r_nxt    = ge ? diff : shifted[WIDTH-1:0];
  assign q_nxt    = {q_acc[WIDTH-2:0], ge};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      op_q    <= '0;
      cnt     <= '0;
      dz      <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      mcand   <= '0;
      prod    <= '0;
      mplier  <= '0;
      r_acc   <= '0;
      q_acc   <= '0;
      res     <= '0;
      rem     <= '0;
      isValid <= 1'b0;
    end else if (accept) begin
      state  <= RUN;
      op_q   <= op;
      a_q    <= num1;
      b_q    <= num2;
      mcand  <= {{WIDTH{1'b0}}, num1};
      mplier <= num2;
      prod   <= '0;
      r_acc  <= '0;
      q_acc  <= num1;
      dz     <= (op == 2'b11) && (num2 == '0);
      // Iterative ops run WIDTH edges; add/sub and div-by-zero finish in one.
      cnt    <= (op[1] && !((op == 2'b11) && (num2 == '0))) ? CW'(WIDTH - 1) : '0;
    end else begin
      case (state)
        RUN: begin
          prod   <= prod_nxt;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          r_acc  <= r_nxt;
          q_acc  <= q_nxt;
          cnt    <= cnt - CW'(1);
          if (cnt == '0) begin
            state <= DONE;
            case (op_q)
              2'b00: begin
                res     <= sum[WIDTH-1:0];
                rem     <= '0;
                isValid <= ~sum[WIDTH];
              end
              2'b01: begin
                res     <= a_q - b_q;
                rem     <= '0;
                isValid <= (a_q >= b_q);
              end
              2'b10: begin
                res     <= prod_nxt[WIDTH-1:0];
                rem     <= '0;
                isValid <= (prod_nxt[2*WIDTH-1:WIDTH] == '0);
              end
              default: begin
                if (dz) begin
                  res     <= '1;
                  rem     <= a_q;
                  isValid <= 1'b0;
                end else begin
                  res     <= q_nxt;
                  rem     <= r_nxt;
                  isValid <= 1'b1;
                end
              end
            endcase
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule
